// File: rtl/apb_uart_regif.sv
// apb_uart_regif
// APB3 slave register interface for a small UART. It exposes a control
// register, a transmit data port, a receive data port and a status word,
// and turns APB transfers into TX FIFO pushes and RX FIFO pops.
//
// Ports:
//   clk, rst          - system/APB clock, synchronous active-high reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata            - APB3 request
//   prdata, pready,
//   pslverr           - APB3 response
//   wren, tx_data     - TX FIFO push strobe and byte
//   rden, rx_data     - RX FIFO pop strobe and head byte
//   uart_ctrl_reg     - stored CTRL value ([0] tx_en, [1] reserved,
//                       [4:2] baud_sel, [5] loopback)
//   uart_status       - live UART status word
module apb_uart_regif #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [5:0]  CTRL_RST   = 6'b000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  wren,
  output logic [7:0]            tx_data,
  output logic                  rden,
  input  logic [7:0]            rx_data,
  output logic [5:0]            uart_ctrl_reg,
  input  logic [7:0]            uart_status
);

  typedef enum logic [1:0] {IDLE, RD_POP, RD_DATA} state_t;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_TXDATA = 2'd1;
  localparam logic [1:0] IDX_RXDATA = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  state_t     state;
  logic [5:0] ctrl;
  logic       wren_q;

  logic       access;
  logic       addr_ok;
  logic [1:0] idx;
  logic       err;
  logic       rx_rd;
  logic       idle_done;
  logic       ctrl_wr;
  logic       tx_wr;
  logic       unused_bits;

  // Address decode and transfer classification. Only word-aligned offsets
  // up to 0xC are legal; any higher address bit being set is out of range.
  // The RXDATA read is the only access that does not finish in the first
  // access cycle, so it is split out as rx_rd and excluded from idle_done.
  always_comb begin
    access    = psel & penable;
    idx       = paddr[3:2];
    addr_ok   = (paddr[1:0] == 2'b00) && (32'(paddr) <= 32'd12);
    err       = !addr_ok
              || (pwrite && (idx == IDX_RXDATA || idx == IDX_STATUS))
              || (!pwrite && idx == IDX_TXDATA);
    rx_rd     = access && (state == IDLE) && !err && !pwrite && (idx == IDX_RXDATA);
    idle_done = access && (state == IDLE) && !rx_rd;
    ctrl_wr   = idle_done && !err && pwrite && (idx == IDX_CTRL);
    tx_wr     = idle_done && !err && pwrite && (idx == IDX_TXDATA);
  end

  assign unused_bits = ^pwdata[31:8];

  // Registered state: CTRL storage, TX byte capture, the one-cycle push
  // strobe and the RXDATA read sequencer. The sequencer always falls back
  // to IDLE after RD_DATA, and leaves RD_POP early if the master drops
  // psel, so a pop is never repeated for one transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ctrl    <= CTRL_RST;
      tx_data <= 8'h00;
      wren_q  <= 1'b0;
    end else begin
      wren_q <= tx_wr;
      if (ctrl_wr) ctrl <= pwdata[5:0];
      if (tx_wr) tx_data <= pwdata[7:0];
      case (state)
        IDLE:    if (rx_rd) state <= RD_POP;
        RD_POP:  state <= psel ? RD_DATA : IDLE;
        RD_DATA: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response path. Everything is forced to its idle value while rst is
  // high so a reset in the middle of a transfer cannot leak a pop, a push
  // or a stale read value. prdata is only non-zero in the completing cycle
  // of a legal read.
  always_comb begin
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = 32'h0;
    rden    = 1'b0;
    wren    = 1'b0;
    if (!rst) begin
      wren = wren_q;
      rden = (state == RD_POP);
      case (state)
        IDLE:    pready = !rx_rd;
        RD_POP:  pready = 1'b0;
        default: pready = 1'b1;
      endcase
      pslverr = idle_done && err;
      if (idle_done && !err && !pwrite) begin
        if (idx == IDX_CTRL)        prdata = {26'h0, ctrl};
        else if (idx == IDX_STATUS) prdata = {24'h0, uart_status};
      end else if (state == RD_DATA && access) begin
        prdata = {24'h0, rx_data};
      end
    end
  end

  assign uart_ctrl_reg = ctrl;

endmodule

// File: tb/tb_apb_uart_regif.sv
// tb_apb_uart_regif
// Directed bench for apb_uart_regif. APB transfers are issued by
// apply_stimulus, which pushes the expected response into a scoreboard
// queue and pops it when the slave completes the transfer. A negedge
// monitor counts push/pop strobes and records the byte on each push.
module tb_apb_uart_regif;

  localparam int         AW   = 5;
  localparam logic [5:0] CRST = 6'h15;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic          wren, rden;
  logic [7:0]    tx_data, rx_data;
  logic [5:0]    uart_ctrl_reg;
  logic [7:0]    uart_status;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] wren_data_q[$];
  int         errors = 0;
  int         checks = 0;
  int         wren_cnt = 0;
  int         rden_cnt = 0;

  always #5 clk = ~clk;

  apb_uart_regif #(.ADDR_WIDTH(AW), .CTRL_RST(CRST)) dut (
    .clk           (clk),
    .rst           (rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .wren          (wren),
    .tx_data       (tx_data),
    .rden          (rden),
    .rx_data       (rx_data),
    .uart_ctrl_reg (uart_ctrl_reg),
    .uart_status   (uart_status)
  );

  // Strobe monitor: counts every high cycle of wren/rden and keeps the
  // byte presented with each push.
  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wren_cnt++;
      wren_data_q.push_back(tx_data);
    end
    if (rden === 1'b1) rden_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_push(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    d = 8'hxx;
    if (wren_data_q.size() > 0) d = wren_data_q.pop_front();
    check_output(tag, 32'(d), 32'(exp));
  endtask

  // One full APB transfer starting 1ns after a rising edge: setup phase,
  // then access phase held until pready (bounded), then back to idle.
  task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_waits, input string tag);
    exp_t        e;
    int          waits;
    logic        got_ready;
    logic [31:0] got_rdata;
    logic        got_err;
    e.tag   = tag;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.waits = exp_waits;
    sb_q.push_back(e);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk);
    #1;
    penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (pready !== 1'b1 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    got_ready = pready;
    got_rdata = prdata;
    got_err   = pslverr;
    e = sb_q.pop_front();
    check_output({e.tag, "_ready"}, 32'(got_ready), 32'd1);
    check_output({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
    check_output({e.tag, "_prdata"}, got_rdata, e.rdata);
    check_output({e.tag, "_pslverr"}, 32'(got_err), 32'(e.err));
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  initial begin
    int w0;
    int r0;
    rst         = 1'b1;
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    paddr       = '0;
    pwdata      = 32'h0;
    rx_data     = 8'h3C;
    uart_status = 8'h5A;

    // Values held while in reset.
    step(3);
    @(negedge clk);
    check_output("rst_ctrl", 32'(uart_ctrl_reg), 32'(CRST));
    check_output("rst_pready", 32'(pready), 32'd1);
    check_output("rst_prdata", prdata, 32'h0);
    check_output("rst_pslverr", 32'(pslverr), 32'd0);
    check_output("rst_wren", 32'(wren), 32'd0);
    check_output("rst_rden", 32'(rden), 32'd0);
    check_output("rst_txdata", 32'(tx_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);

    // CTRL write then read back.
    apply_stimulus(1'b1, 5'h00, 32'h0000_002D, 32'h0, 1'b0, 0, "wr_ctrl");
    check_output("ctrl_after_wr", 32'(uart_ctrl_reg), 32'h2D);
    apply_stimulus(1'b0, 5'h00, 32'h0, 32'h0000_002D, 1'b0, 0, "rd_ctrl");

    // TXDATA write: one push strobe in the cycle after completion.
    w0 = wren_cnt;
    r0 = rden_cnt;
    apply_stimulus(1'b1, 5'h04, 32'h0000_01A5, 32'h0, 1'b0, 0, "wr_tx");
    check_output("tx_data", 32'(tx_data), 32'hA5);
    @(negedge clk);
    check_output("wren_pulse_hi", 32'(wren), 32'd1);
    @(negedge clk);
    check_output("wren_pulse_lo", 32'(wren), 32'd0);
    @(posedge clk);
    #1;
    check_output("wren_count", 32'(wren_cnt - w0), 32'd1);
    check_push("wren_byte", 8'hA5);
    check_output("tx_no_rden", 32'(rden_cnt - r0), 32'd0);

    // RXDATA read: two wait states, one pop.
    w0 = wren_cnt;
    r0 = rden_cnt;
    apply_stimulus(1'b0, 5'h08, 32'h0, 32'h0000_003C, 1'b0, 2, "rd_rx");
    step(1);
    check_output("rx_rden_count", 32'(rden_cnt - r0), 32'd1);
    check_output("rx_no_wren", 32'(wren_cnt - w0), 32'd0);

    // STATUS read.
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0000_005A, 1'b0, 0, "rd_status");

    // Error accesses: no wait states, no side effects.
    w0 = wren_cnt;
    r0 = rden_cnt;
    apply_stimulus(1'b1, 5'h0C, 32'h0000_003F, 32'h0, 1'b1, 0, "err_wr_status");
    apply_stimulus(1'b0, 5'h04, 32'h0, 32'h0, 1'b1, 0, "err_rd_tx");
    apply_stimulus(1'b0, 5'h02, 32'h0, 32'h0, 1'b1, 0, "err_unaligned");
    apply_stimulus(1'b1, 5'h10, 32'h0000_003F, 32'h0, 1'b1, 0, "err_range");
    apply_stimulus(1'b1, 5'h08, 32'h0000_003F, 32'h0, 1'b1, 0, "err_wr_rx");
    step(2);
    check_output("err_no_wren", 32'(wren_cnt - w0), 32'd0);
    check_output("err_no_rden", 32'(rden_cnt - r0), 32'd0);
    check_output("err_ctrl_kept", 32'(uart_ctrl_reg), 32'h2D);

    // Reset while in RD_POP aborts the read without a pop.
    r0 = rden_cnt;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 5'h08;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("rstpop_rden", 32'(rden), 32'd0);
    check_output("rstpop_pready", 32'(pready), 32'd1);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check_output("rstpop_idle_pready", 32'(pready), 32'd1);
    check_output("rstpop_idle_rden", 32'(rden), 32'd0);
    check_output("rstpop_ctrl", 32'(uart_ctrl_reg), 32'(CRST));
    check_output("rstpop_pop_count", 32'(rden_cnt - r0), 32'd0);
    @(posedge clk);
    #1;
    uart_status = 8'hA7;
    apply_stimulus(1'b0, 5'h0C, 32'h0, 32'h0000_00A7, 1'b0, 0, "rd_status_after_rst");

    // Reset during a TXDATA completing cycle: the push never happens.
    w0 = wren_cnt;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 5'h04;
    pwdata  = 32'h0000_0077;
    @(posedge clk);
    #1;
    penable = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    step(2);
    check_output("rsttx_no_wren", 32'(wren_cnt - w0), 32'd0);
    check_output("rsttx_txdata", 32'(tx_data), 32'd0);

    // Back-to-back TXDATA writes give two separate pushes in order.
    w0 = wren_cnt;
    wren_data_q.delete();
    apply_stimulus(1'b1, 5'h04, 32'h0000_0011, 32'h0, 1'b0, 0, "wr_tx_11");
    apply_stimulus(1'b1, 5'h04, 32'h0000_0022, 32'h0, 1'b0, 0, "wr_tx_22");
    step(2);
    check_output("b2b_wren_count", 32'(wren_cnt - w0), 32'd2);
    check_push("b2b_byte0", 8'h11);
    check_push("b2b_byte1", 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
